test_port_writer: RTL and testbench

TEST_PORT_WRITER -- requirements
Module: test_port_writer

---
 rtl/tpw_pkg.sv | 23 ++
 rtl/tpw_fifo.sv | 62 ++++++
 rtl/test_port_writer.sv | 139 +++++++++++++
 tb/tb_test_port_writer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpw_pkg.sv
// tpw_pkg: shared definitions for test_port_writer and its FIFO.
// Holds the FSM state encoding, default report constants and byte-swap.
package tpw_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEGIN = 3'd1,
        GAP      = 3'd2,
        WR_DATA  = 3'd3,
        WR_END   = 3'd4,
        DONE     = 3'd5
    } tpw_state_t;

    localparam logic [29:0] TPW_TEST_PORT = 30'h3FF;
    localparam logic [31:0] TPW_BEGIN_SYM = 32'h0000_0168;
    localparam logic [31:0] TPW_END_SYM   = 32'hFFFF_FD5D;

    // Reverse byte order: big-endian word to little-endian memory image.
    function automatic logic [31:0] tpw_bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/tpw_fifo.sv
// tpw_fifo: result FIFO for test_port_writer (DEPTH power of two).
// Ports: clk, rst (async low), push/push_data, pop/pop_data, full, empty, count.
module tpw_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [31:0]              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A push into a full FIFO only lands when a pop frees the slot
    // in the same cycle; otherwise it is dropped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/test_port_writer.sv
// test_port_writer: writes BEGIN_SYM, queued results, END_SYM to a test port.
// Ports: clk, rst (async low), res_valid/res_data/res_ready (result push),
//   start, mem_addr/mem_wdata/mem_wen/mem_stall (write port), busy, done.
// Build option: define TPW_BYTESWAP_EN to byte-swap every written word.
module test_port_writer
    import tpw_pkg::*;
#(
    parameter logic [29:0] TEST_PORT = TPW_TEST_PORT,
    parameter logic [31:0] BEGIN_SYM = TPW_BEGIN_SYM,
    parameter logic [31:0] END_SYM   = TPW_END_SYM,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    input  logic        start,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic        mem_stall,
    output logic        busy,
    output logic        done
);

    tpw_state_t state;
    tpw_state_t state_nx;

    logic                   drain;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [31:0]            fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   count_unused;
    logic [31:0]            word;

    assign res_ready    = !fifo_full;
    assign fifo_push    = res_valid && res_ready;
    assign fifo_pop     = (state == WR_DATA) && !mem_stall;
    assign count_unused = ^fifo_count;

    tpw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (res_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Drain request: a second start while a report is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain <= 1'b0;
        end else if (state_nx == DONE && state != DONE) begin
            drain <= 1'b0;
        end else if (start && busy) begin
            drain <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = WR_BEGIN;
            end
            WR_BEGIN, WR_DATA: begin
                if (!mem_stall) state_nx = GAP;
            end
            GAP: begin
                if (!fifo_empty) begin
                    state_nx = WR_DATA;
                end else if (drain) begin
                    state_nx = WR_END;
                end
            end
            WR_END: begin
                if (!mem_stall) state_nx = DONE;
            end
            DONE: begin
                if (start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from state, so an async reset drops
    // mem_wen in the same cycle, even mid-stall.
    always_comb begin
        word    = '0;
        mem_wen = 1'b0;
        unique case (state)
            WR_BEGIN: begin
                word    = BEGIN_SYM;
                mem_wen = 1'b1;
            end
            WR_DATA: begin
                word    = fifo_head;
                mem_wen = 1'b1;
            end
            WR_END: begin
                word    = END_SYM;
                mem_wen = 1'b1;
            end
            default: begin
                word    = '0;
                mem_wen = 1'b0;
            end
        endcase
    end

`ifdef TPW_BYTESWAP_EN
    assign mem_wdata = tpw_bswap(word);
`else
    assign mem_wdata = word;
`endif

    assign mem_addr = TEST_PORT;
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_test_port_writer.sv
// tb_test_port_writer: directed bench with a report-level scoreboard.
// Drives inputs #1 after posedge, checks outputs on negedge.
module tb_test_port_writer;

    localparam int          DEPTH = 8;
    localparam logic [29:0] TP    = 30'h3FF;
    localparam logic [31:0] BSYM  = 32'h0000_0168;
    localparam logic [31:0] ESYM  = 32'hFFFF_FD5D;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        start;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_stall;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    test_port_writer #(
        .TEST_PORT (TP),
        .BEGIN_SYM (BSYM),
        .END_SYM   (ESYM),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_stall (mem_stall),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit hit, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef TPW_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- write-port stall generator ----------------
    int pulse_idx = 0;
    int stall_at  = -1;
    int stall_len = 0;
    int s_left    = 0;
    bit s_held    = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            s_left    = 0;
            s_held    = 0;
            mem_stall = 1'b0;
        end else begin
            if (mem_wen && !s_held) begin
                pulse_idx++;
                if (pulse_idx == stall_at) s_left = stall_len;
            end
            mem_stall = mem_wen && (s_left > 0);
            if (mem_stall) s_left--;
            s_held = mem_stall;
        end
    end

    // ---------------- report-level scoreboard ----------------
    logic [31:0] m_q[$];
    logic [31:0] got_w[$];
    int          got_l[$];
    bit          m_begun = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          held    = 0;
    bit          gap_due = 0;
    bit          m_acc;
    logic [31:0] held_word;
    logic [31:0] m_exp;
    int          kind = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_begun = 0;
            m_busy  = 0;
            m_done  = 0;
            held    = 0;
            gap_due = 0;
        end else begin
            chk("res_ready", 32'(res_ready), 32'(m_q.size() < DEPTH));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("mem_addr", 32'(mem_addr), 32'(TP));
            m_acc = res_valid && (m_q.size() < DEPTH);
            if (start) begin
                if (m_done) m_done = 0;
                else if (!m_busy) m_busy = 1;
            end
            if (mem_wen) begin
                if (gap_due) chk("wen_gap", 32'(mem_wen), 32'd0);
                if (held) begin
                    chk("hold_data", mem_wdata, held_word);
                end else begin
                    if (!m_begun) begin
                        kind  = 0;
                        m_exp = sw(BSYM);
                    end else if (m_q.size() > 0) begin
                        kind  = 1;
                        m_exp = sw(m_q[0]);
                    end else begin
                        kind  = 2;
                        m_exp = sw(ESYM);
                    end
                    chk("word", mem_wdata, m_exp);
                    got_w.push_back(mem_wdata);
                    got_l.push_back(0);
                end
                if (got_l.size() > 0) got_l[got_l.size()-1] += 1;
                held      = mem_stall;
                held_word = mem_wdata;
                gap_due   = !mem_stall;
                if (!mem_stall) begin
                    case (kind)
                        0: m_begun = 1;
                        1: void'(m_q.pop_front());
                        default: begin
                            m_begun = 0;
                            m_busy  = 0;
                            m_done  = 1;
                        end
                    endcase
                end
            end else begin
                chk("idle_wdata", mem_wdata, 32'd0);
                held    = 0;
                gap_due = 0;
            end
            if (m_acc) m_q.push_back(res_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        res_valid = 1'b1;
        res_data  = w;
        step();
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done; i++) step();
        chk("wait_done", 32'(done), 32'd1);
    endtask

    // start, drain on the very next cycle, wait, then return to IDLE
    task automatic run_report();
        got_w.delete();
        got_l.delete();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_done(400);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic check_words(input logic [31:0] e[$]);
        chk("n_words", 32'(got_w.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_w.size(); i++) begin
            chk($sformatf("word_%0d", i), got_w[i], e[i]);
        end
    endtask

    logic [31:0] exp_q[$];
    int          target;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h3FF);
        rst = 1'b1;
        step();

        // basic report
        push(32'd0); push(32'd1); push(32'd1);
        push(32'd1); push(32'd1); push(32'd0);
        run_report();
        exp_q = '{sw(32'h168), 32'd0, sw(32'd1), sw(32'd1), sw(32'd1),
                  sw(32'd1), 32'd0, sw(32'hFFFFFD5D)};
        check_words(exp_q);

        // stall on the 3rd write for 5 cycles
        stall_at  = pulse_idx + 3;
        stall_len = 5;
        push(32'hA000_0001); push(32'hA000_0002); push(32'hA000_0003);
        run_report();
        exp_q = '{sw(32'h168), sw(32'hA000_0001), sw(32'hA000_0002),
                  sw(32'hA000_0003), sw(32'hFFFFFD5D)};
        check_words(exp_q);
        if (got_l.size() >= 3) chk("stall_len", 32'(got_l[2]), 32'd6);
        else chk("stall_pulses", 32'(got_l.size()), 32'd5);
        if (got_l.size() >= 2) chk("plain_len", 32'(got_l[1]), 32'd1);
        stall_at  = -1;
        stall_len = 0;

        // full FIFO: 9 pushes, the 9th dropped
        for (int i = 0; i < 9; i++) begin
            push(32'h100 + 32'(i));
            if (i == 7) chk("full_ready", 32'(res_ready), 32'd0);
        end
        run_report();
        exp_q = '{sw(32'h168)};
        for (int i = 0; i < 8; i++) exp_q.push_back(sw(32'h100 + 32'(i)));
        exp_q.push_back(sw(32'hFFFFFD5D));
        check_words(exp_q);

        // late data: block waits in GAP between words
        got_w.delete();
        got_l.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (5) step();
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_wen", 32'(mem_wen), 32'd0);
            repeat (5) step();
            push(32'hC0DE_0000 + 32'(k));
        end
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        exp_q = '{sw(32'h168), sw(32'hC0DE_0000), sw(32'hC0DE_0001),
                  sw(32'hC0DE_0002), sw(32'hFFFFFD5D)};
        check_words(exp_q);

        // reset during a stalled WR_DATA
        push(32'hDEAD_0001);
        target    = pulse_idx + 2;
        stall_at  = target;
        stall_len = 50;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        for (int i = 0; i < 30 && pulse_idx < target; i++) step();
        chk("wait_pulse", 32'(pulse_idx >= target), 32'd1);
        step();
        step();
        chk("pre_rst_wen", 32'(mem_wen), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_wen", 32'(mem_wen), 32'd0);
        chk("async_wdata", mem_wdata, 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        stall_at  = -1;
        stall_len = 0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_ready", 32'(res_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        run_report();
        exp_q = '{sw(32'h168), sw(32'hFFFFFD5D)};
        check_words(exp_q);

        // byte order of a data word
        push(32'h1234_5678);
        run_report();
`ifdef TPW_BYTESWAP_EN
        exp_q = '{32'h6801_0000, 32'h7856_3412, 32'h5DFD_FFFF};
`else
        exp_q = '{32'h0000_0168, 32'h1234_5678, 32'hFFFF_FD5D};
`endif
        check_words(exp_q);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
